// File: rtl/color_pkg.sv
// Shared color encoding and lane count for the randomizer, queue and game logic.
package color_pkg;
  typedef logic [2:0] color_t;

  localparam color_t NONE   = 3'b000;
  localparam color_t PURPLE = 3'b001;
  localparam color_t ORANGE = 3'b010;
  localparam color_t YELLOW = 3'b011;
  localparam color_t BLUE   = 3'b100;
  localparam color_t RED    = 3'b101;
  localparam color_t GREEN  = 3'b110;

  localparam int LANES = 5;

  function automatic logic is_invalid(input color_t c);
    return (c == 3'b000) || (c == 3'b111);
  endfunction

  function automatic color_t sanitize(input color_t c);
    return is_invalid(c) ? PURPLE : c;
  endfunction

  // Cycles through the six legal colors, GREEN wraps back to PURPLE.
  function automatic color_t next_color(input color_t c);
    return (c == GREEN) ? PURPLE : color_t'(c + 3'd1);
  endfunction
endpackage

// File: rtl/color_fifo.sv
// Circular color store; pops on empty are dropped, head reads NONE when empty.
module color_fifo
  import color_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  color_t                   data,
  output color_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  color_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic            pop_ok, push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head = (count == '0) ? NONE : mem[rptr];
endmodule

// File: rtl/color_queue.sv
// Captures 5-lane color batches and feeds them one per cycle into color_fifo.
// Optional COLOR_QUEUE_NO_REPEAT_EN bumps a color equal to the previous push.
module color_queue
  import color_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  color_t                   random_color [0:LANES-1],
  input  logic                     fill_en,
  input  logic                     color_pop,
  output color_t                   color_out,
  output logic                     color_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     loading,
  output logic                     err_invalid
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ROOM = CW'(DEPTH - LANES);
  localparam logic [2:0] LAST_IDX = 3'(LANES - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [2:0]        idx;
  color_t            snap     [LANES];
  color_t            lane_fix [LANES];
  logic [LANES-1:0]  lane_bad;
  logic              capture, push;
  color_t            push_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_fix[i] = sanitize(random_color[i]);
    assign lane_bad[i] = is_invalid(random_color[i]);
  end

  // Space check guarantees the whole batch fits, so pushes never stall.
  assign capture = (state == IDLE) && fill_en && (count <= ROOM);
  assign push    = (state == LOAD);

`ifdef COLOR_QUEUE_NO_REPEAT_EN
  color_t last;

  always_comb begin
    push_data = snap[idx];
    if (push_data == last) push_data = next_color(push_data);
  end

  // NONE never matches a sanitized color, so the first push after reset is untouched.
  always_ff @(posedge clk) begin
    if (rst)       last <= NONE;
    else if (push) last <= push_data;
  end
`else
  always_comb begin
    push_data = snap[idx];
  end
`endif

  always_ff @(posedge clk) begin
    if (capture) snap <= lane_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      loading     <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (capture) begin
          state   <= LOAD;
          idx     <= '0;
          loading <= 1'b1;
          if (|lane_bad) err_invalid <= 1'b1;
        end
        LOAD: if (idx == LAST_IDX) begin
          state   <= IDLE;
          idx     <= '0;
          loading <= 1'b0;
        end else begin
          idx <= idx + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  color_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (color_pop),
    .data  (push_data),
    .head  (color_out),
    .count (count)
  );

  assign color_valid = (count != '0);
endmodule

// File: tb/tb_color_queue.sv
// Self-checking bench for color_queue against a queue-based batch model.
module tb_color_queue;
  localparam int DEPTH = 8;
`ifdef COLOR_QUEUE_NO_REPEAT_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, fill_en, color_pop;
  logic [2:0] rc [0:4];
  logic [2:0] color_out;
  logic       color_valid, loading, err_invalid;
  logic [3:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: fifo contents, colors still waiting to be pushed, last pushed color, sticky error.
  logic [2:0] q[$];
  logic [2:0] pend[$];
  logic [2:0] last;
  bit         err;

  always #5 clk = ~clk;

  color_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .random_color (rc),
    .fill_en      (fill_en),
    .color_pop    (color_pop),
    .color_out    (color_out),
    .color_valid  (color_valid),
    .count        (count),
    .loading      (loading),
    .err_invalid  (err_invalid)
  );

  function automatic logic [2:0] m_head();
    return (q.size() != 0) ? q[0] : 3'b000;
  endfunction

  task automatic model(input bit r, input bit f, input bit p);
    int pre;
    bit pe;
    logic [2:0] v;
    if (r) begin
      q.delete(); pend.delete(); last = 3'b000; err = 1'b0;
      return;
    end
    pre = q.size();
    pe  = (pend.size() == 0);
    if (p && pre > 0) q.delete(0);
    if (!pe) begin
      v = pend.pop_front();
      if (NOREP && v == last) v = (v == 3'd6) ? 3'd1 : 3'(v + 3'd1);
      q.push_back(v);
      last = v;
    end
    if (pe && f && pre <= DEPTH - 5) begin
      for (int i = 0; i < 5; i++) begin
        v = rc[i];
        if (v == 3'd0 || v == 3'd7) begin v = 3'd1; err = 1'b1; end
        pend.push_back(v);
      end
    end
  endtask

  task automatic step(input bit r, input bit f, input bit p);
    rst = r; fill_en = f; color_pop = p;
    @(posedge clk);
    model(r, f, p);
    #1;
  endtask

  task automatic set_lanes(input logic [2:0] a, b, c, d, e);
    rc[0] = a; rc[1] = b; rc[2] = c; rc[3] = d; rc[4] = e;
  endtask

  task automatic test_reset();
    set_lanes(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (color_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", color_valid); end
    n_cmp++; if (color_out !== 3'b000) begin n_bad++; $display("FAIL reset_out got %b want 000", color_out); end
    n_cmp++; if (loading !== 1'b0) begin n_bad++; $display("FAIL reset_loading got %b want 0", loading); end
    n_cmp++; if (err_invalid !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_invalid); end
  endtask

  task automatic test_basic();
    logic [2:0] exp_b [5];
    if (NOREP) exp_b = '{3'd3, 3'd5, 3'd3, 3'd4, 3'd5};
    else       exp_b = '{3'd3, 3'd5, 3'd3, 3'd3, 3'd5};
    set_lanes(3'd3, 3'd5, 3'd3, 3'd3, 3'd5);
    step(0, 1, 0);
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL basic_load_start got %b want 1", loading); end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      n_cmp++; if (loading !== (k < 4)) begin n_bad++; $display("FAIL basic_loading[%0d] got %b want %b", k, loading, (k < 4)); end
      if (k == 0) begin
        n_cmp++; if (color_valid !== 1'b1) begin n_bad++; $display("FAIL basic_first_valid got %b want 1", color_valid); end
      end
    end
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL basic_count got %0d want 5", count); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (color_out !== exp_b[i]) begin n_bad++; $display("FAIL basic_pop[%0d] got %b want %b", i, color_out, exp_b[i]); end
      step(0, 0, 1);
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL basic_drained got %0d want 0", count); end
  endtask

  task automatic test_space();
    set_lanes(3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    step(0, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    step(0, 0, 1);
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL space_count4 got %0d want 4", count); end
    step(0, 1, 0);
    n_cmp++; if (loading !== 1'b0 || count !== 4'd4) begin n_bad++; $display("FAIL space_no_capture loading=%b count=%0d want 0/4", loading, count); end
    step(0, 0, 1);
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL space_count3 got %0d want 3", count); end
    set_lanes(3'd6, 3'd5, 3'd4, 3'd3, 3'd2);
    step(0, 1, 0);
    n_cmp++; if (loading !== 1'b1) begin n_bad++; $display("FAIL space_capture got %b want 1", loading); end
    // Lanes and fill_en keep changing during LOAD and must be ignored.
    for (int k = 0; k < 5; k++) begin
      set_lanes(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      step(0, 1, 0);
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL space_full got %0d want 8", count); end
    step(0, 1, 0);
    n_cmp++; if (count !== 4'd8 || loading !== 1'b0) begin n_bad++; $display("FAIL space_full_hold count=%0d loading=%b want 8/0", count, loading); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (color_out !== m_head()) begin n_bad++; $display("FAIL space_pop[%0d] got %b want %b", i, color_out, m_head()); end
      step(0, 0, 1);
    end
    step(0, 0, 1);
    n_cmp++; if (count !== 4'd0 || color_valid !== 1'b0) begin n_bad++; $display("FAIL space_empty_pop count=%0d valid=%b want 0/0", count, color_valid); end
  endtask

  task automatic test_pop_push();
    set_lanes(3'd2, 3'd4, 3'd6, 3'd2, 3'd4);
    step(0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1);
      n_cmp++; if (count !== ((k < 5) ? 4'd1 : 4'd0)) begin n_bad++; $display("FAIL pp_count[%0d] got %0d want %0d", k, count, (k < 5) ? 1 : 0); end
      n_cmp++; if (color_out !== m_head()) begin n_bad++; $display("FAIL pp_out[%0d] got %b want %b", k, color_out, m_head()); end
    end
  endtask

  task automatic test_rst_mid_load();
    set_lanes(3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 1);
    n_cmp++; if (count !== 4'd0 || color_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid count=%0d valid=%b want 0/0", count, color_valid); end
    n_cmp++; if (color_out !== 3'b000 || loading !== 1'b0) begin n_bad++; $display("FAIL rst_mid out=%b loading=%b want 000/0", color_out, loading); end
    for (int k = 0; k < 6; k++) step(0, 0, 0);
    n_cmp++; if (count !== 4'd0 || loading !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after count=%0d loading=%b want 0/0", count, loading); end
  endtask

  task automatic test_invalid();
    logic [2:0] exp_i [5];
    exp_i = '{3'd2, 3'd4, 3'd1, 3'd6, 3'd3};
    set_lanes(3'd2, 3'd4, 3'd7, 3'd6, 3'd3);
    step(0, 1, 0);
    n_cmp++; if (err_invalid !== 1'b1) begin n_bad++; $display("FAIL inv_err_set got %b want 1", err_invalid); end
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (color_out !== exp_i[i]) begin n_bad++; $display("FAIL inv_pop[%0d] got %b want %b", i, color_out, exp_i[i]); end
      step(0, 0, 1);
    end
    n_cmp++; if (err_invalid !== 1'b1) begin n_bad++; $display("FAIL inv_err_sticky got %b want 1", err_invalid); end
    step(1, 0, 0);
    n_cmp++; if (err_invalid !== 1'b0) begin n_bad++; $display("FAIL inv_err_clear got %b want 0", err_invalid); end
  endtask

  task automatic test_random();
    bit r, f, p;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 5; i++) rc[i] = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 79) == 0);
      f = ($urandom_range(0, 2) == 0);
      p = $urandom_range(0, 1);
      step(r, f, p);
      n_cmp++;
      if (count !== 4'(q.size()) || color_out !== m_head() || color_valid !== (q.size() != 0) ||
          loading !== (pend.size() != 0) || err_invalid !== err) begin
        n_bad++;
        $display("FAIL rand[%0d] got cnt=%0d out=%b vld=%b ld=%b err=%b want cnt=%0d out=%b vld=%b ld=%b err=%b",
                 c, count, color_out, color_valid, loading, err_invalid,
                 q.size(), m_head(), (q.size() != 0), (pend.size() != 0), err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; fill_en = 1'b0; color_pop = 1'b0;
    for (int i = 0; i < 5; i++) rc[i] = 3'd0;
    last = 3'b000; err = 1'b0;
    test_reset();
    test_basic();
    test_space();
    test_pop_push();
    test_rst_mid_load();
    test_invalid();
    step(1, 0, 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/color_queue.md
COLOR_QUEUE -- requirements
Module: color_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two, minimum 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port random_color, input, 3 bits x 5 lanes [0:4]: color codes from the LFSR randomizer stage.
REQ-005 SHALL have port fill_en, input, 1 bit: permits capture of a new 5-lane batch.
REQ-006 SHALL have port color_pop, input, 1 bit: consumer accepts the head color.
REQ-007 SHALL have port color_out, output, 3 bits: head color, or 3'b000 when empty.
REQ-008 SHALL have port color_valid, output, 1 bit: FIFO not empty.
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-010 SHALL have port loading, output, 1 bit: high while in state LOAD.
REQ-011 SHALL have port err_invalid, output, 1 bit: sticky flag, set when an invalid code (000 or 111) is captured.

Function
REQ-012 SHALL implement FSM states IDLE and LOAD.
REQ-013 In IDLE, when fill_en=1 and count<=DEPTH-5, SHALL register all 5 lanes into a snapshot on that edge, clear lane index idx to 0, and enter LOAD.
REQ-014 In LOAD, SHALL push snapshot[idx] on each cycle for idx 0..4, then return to IDLE after the idx=4 push; a batch therefore takes exactly 5 cycles with no gaps.
REQ-015 SHALL ignore random_color and fill_en while in LOAD.
REQ-016 Latency: when fill_en is sampled on edge N, the first push occurs on edge N+1 and color_valid is high after edge N+1.
REQ-017 A captured code of 000 or 111 SHALL be pushed as PURPLE (001) and SHALL set err_invalid.
REQ-018 color_pop SHALL be accepted only when color_valid=1; a pop while empty SHALL be ignored with no state change.
REQ-019 A push and an accepted pop in the same cycle SHALL leave count unchanged; the pushed entry follows the remaining entries in order.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH, guaranteed by the REQ-013 space check.
REQ-021 color_out SHALL be combinational from the head entry; it changes the cycle after an accepted pop.
REQ-022 Order SHALL be strictly FIFO, with lanes pushed in order 0,1,2,3,4.

Reset
REQ-023 When rst=1, SHALL set state IDLE, idx 0, pointers 0, count 0, color_valid 0, color_out 000, loading 0, err_invalid 0.
REQ-024 rst asserted mid-LOAD SHALL abandon the batch and empty the FIFO; no partial entries survive.
REQ-025 rst SHALL take priority over fill_en and color_pop in the same cycle.

Configuration
REQ-026 With macro COLOR_QUEUE_NO_REPEAT_EN defined, a value equal to the last pushed color SHALL be pushed as the next code instead, wrapping 110->001.
REQ-027 The last-pushed history for COLOR_QUEUE_NO_REPEAT_EN SHALL clear on reset, so the first push after reset is never modified.
REQ-028 Without COLOR_QUEUE_NO_REPEAT_EN, SHALL push values unmodified, apart from the REQ-017 substitution.

Structure
REQ-029 Package color_pkg SHALL hold color_t (3-bit), the constants PURPLE=001, ORANGE=010, YELLOW=011, BLUE=100, RED=101, GREEN=110 and NONE=000, and the lane count 5; it is shared with the randomizer and the game logic.
REQ-030 Storage SHALL live in sub-module color_fifo (DEPTH, push, pop, data, count); the FSM and lane sequencing SHALL live in color_queue.

Verification
REQ-031 SHALL verify: reset, then lanes {011,101,011,011,101} with fill_en for 1 cycle -> loading high for 5 cycles, count reaches 5, and 5 pops yield 011,101,011,011,101.
REQ-032 SHALL verify: count=4 with DEPTH=8 and fill_en=1 -> no capture; after 1 pop (count=3) -> capture, and count reaches 8 with no overflow.
REQ-033 SHALL verify: color_pop held high with a push in the same cycle -> count stays 1 and output order is preserved.
REQ-034 SHALL verify: rst pulsed on the 3rd LOAD cycle -> count=0, color_valid=0, color_out=000, loading=0 on the next cycle.
REQ-035 SHALL verify: lane 2 = 111 -> PURPLE (001) is pushed in slot 2 and err_invalid stays high until rst.
REQ-036 SHALL verify: with COLOR_QUEUE_NO_REPEAT_EN, lanes {011,101,011,011,101} -> pushed sequence is 011,101,011,100,101.
